bus_timer_irq: RTL

- Memory-mapped bus responder on the 65C02 core's external bus; the core is the initiator.
- Decodes the core's address, write-enable and data-out, and returns read data one cycle later, matching the core's synchronous-memory timing.
- Contains a prescaled 16-bit down-counter timer and a 4-input edge-latched interrupt collector.
- Drives the core's irq input.

---
 rtl/bus_timer_irq_if.sv | 19 +
 rtl/bus_timer_irq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bus_timer_irq_if.sv
// Core-side external bus of the 65C02: address, write data and
// write enable from the core, registered read data and select back.
interface bus_timer_irq_if;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DI;
    logic        sel;

    modport master (
        output AB, DO, WE,
        input  DI, sel
    );

    modport slave (
        input  AB, DO, WE,
        output DI, sel
    );
endinterface

// File: rtl/bus_timer_irq.sv
// 8-byte register window on the 65C02 bus: prescaled 16-bit
// down-counter timer plus a 4-line edge-latched interrupt collector.
module bus_timer_irq #(
    parameter logic [15:0] BASE = 16'hFE00,
    parameter int          NEXT = 4
) (
    input  logic            clk,
    input  logic            reset,
    bus_timer_irq_if.slave  bus,
    input  logic [NEXT-1:0] ext_irq,
    output logic            irq
);
    localparam logic [2:0] R_CNT_LO = 3'd0;
    localparam logic [2:0] R_CNT_HI = 3'd1;
    localparam logic [2:0] R_CTRL   = 3'd2;
    localparam logic [2:0] R_STATUS = 3'd3;
    localparam logic [2:0] R_PSC    = 3'd4;

    logic [15:0]     counter;
    logic [15:0]     reload;
    logic [7:0]      shadow;
    logic [7:0]      prescale;
    logic [7:0]      psc;
    logic [7:0]      ctrl;
    logic [7:0]      ctrl_n;
    logic            flag;
    logic [NEXT-1:0] pending;
    logic [NEXT-1:0] ext_d;
    logic [7:0]      rdata;

    logic       hit;
    logic [2:0] off;
    logic       wr;
    logic       rd;
    logic       wr_lo;
    logic       wr_hi;
    logic       wr_ctrl;
    logic       wr_stat;
    logic       wr_psc;
    logic       tick;
    logic       uf;

    assign hit     = (bus.AB[15:3] == BASE[15:3]);
    assign off     = bus.AB[2:0];
    assign wr      = hit & bus.WE;
    assign rd      = hit & ~bus.WE;
    assign wr_lo   = wr & (off == R_CNT_LO);
    assign wr_hi   = wr & (off == R_CNT_HI);
    assign wr_ctrl = wr & (off == R_CTRL);
    assign wr_stat = wr & (off == R_STATUS);
    assign wr_psc  = wr & (off == R_PSC);

    // A CNT_HI write reloads the counter, so any tick that cycle is dropped.
    assign tick = ctrl[0] & (psc == 8'd0);
    assign uf   = tick & ~wr_hi & (counter == 16'd0);

    // Register read mux for the current address.
    always_comb begin
        rdata = 8'h00;
        case (off)
            R_CNT_LO: rdata = counter[7:0];
            R_CNT_HI: rdata = shadow;
            R_CTRL:   rdata = ctrl;
            R_STATUS: rdata = {pending, 3'b000, flag};
            R_PSC:    rdata = prescale;
            default:  rdata = 8'h00;
        endcase
    end

    // Next CTRL: written value, forced run on CNT_HI load, stop on one-shot underflow.
    always_comb begin
        ctrl_n = ctrl;
        if (wr_ctrl)
            ctrl_n = bus.DO & 8'hF7;
        if (wr_hi)
            ctrl_n[0] = 1'b1;
        if (uf & ~ctrl[1])
            ctrl_n[0] = 1'b0;
    end

    // Read data and select follow the address by exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.DI  <= 8'h00;
            bus.sel <= 1'b0;
        end else begin
            bus.sel <= hit;
            bus.DI  <= rd ? rdata : 8'h00;
        end
    end

    // Software-written configuration and the coherent-read shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            reload   <= 16'h0000;
            prescale <= 8'h00;
            shadow   <= 8'h00;
            ctrl     <= 8'h00;
        end else begin
            if (wr_lo)
                reload[7:0] <= bus.DO;
            if (wr_hi)
                reload[15:8] <= bus.DO;
            if (wr_psc)
                prescale <= bus.DO;
            if (rd && off == R_CNT_LO)
                shadow <= counter[15:8];
            ctrl <= ctrl_n;
        end
    end

    // Prescaler divides clk by PRESCALE+1 while running.
    always_ff @(posedge clk) begin
        if (reset)
            psc <= 8'h00;
        else if (wr_hi)
            psc <= 8'h00;
        else if (ctrl[0])
            psc <= (psc == 8'd0) ? prescale : psc - 8'd1;
    end

    // Main counter: load on CNT_HI write, count down on ticks.
    always_ff @(posedge clk) begin
        if (reset)
            counter <= 16'h0000;
        else if (wr_hi)
            counter <= {bus.DO, reload[7:0]};
        else if (tick) begin
            if (counter != 16'd0)
                counter <= counter - 16'd1;
            else if (ctrl[1])
                counter <= reload;
        end
    end

    // Status bits: new events beat a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag    <= 1'b0;
            pending <= '0;
            ext_d   <= '0;
        end else begin
            flag    <= (flag & ~(wr_stat & bus.DO[0])) | uf;
            pending <= (pending & ~({NEXT{wr_stat}} & bus.DO[7:4]))
                     | (ext_irq & ~ext_d);
            ext_d   <= ext_irq;
        end
    end

    // Registered interrupt request from enabled sources.
    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= (flag & ctrl[2]) | (|(pending & ctrl[7:4]));
    end
endmodule
